// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin two-master arbiter for one Avalon-style slave port.
// A grant is held until the slave completes the transfer or the stall watchdog aborts it.
module mips_bus_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        bus_error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             g0;
    logic             g1;
    logic             gnt;
    logic             req0;
    logic             req1;
    logic             done;
    logic             abort;
    logic             drive;
    logic             sel_rd;
    logic             sel_wr;

    assign g0     = (state == GNT0);
    assign g1     = (state == GNT1);
    assign gnt    = g0 | g1;
    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign done   = gnt & ~waitrequest;
    assign abort  = gnt & waitrequest & WD_EN & (cnt == LIMIT);
    assign drive  = gnt & ~abort;
    assign sel_rd = g1 ? m1_read : m0_read;
    assign sel_wr = g1 ? m1_write : m0_write;

    // A simultaneous read+write request is treated as a write.
    assign read       = drive & sel_rd & ~sel_wr;
    assign write      = drive & sel_wr;
    assign address    = drive ? (g1 ? m1_address : m0_address) : '0;
    assign writedata  = drive ? (g1 ? m1_writedata : m0_writedata) : '0;
    assign byteenable = drive ? (g1 ? m1_byteenable : m0_byteenable) : '0;
    assign bus_error  = abort;

    assign m0_waitrequest = ~(g0 & (done | abort));
    assign m1_waitrequest = ~(g1 & (done | abort));
    assign m0_readdata    = (g0 & done) ? readdata : '0;
    assign m1_readdata    = (g1 & done) ? readdata : '0;

    // Outside a grant (including the unused encoding) behave as IDLE.
    assign state_nx = !gnt ? ((req0 && (!req1 || last)) ? GNT0 : req1 ? GNT1 : IDLE)
                           : (done || abort) ? IDLE : state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (gnt && (done || abort)) begin
                last <= g1;
                cnt  <= '0;
            end else if (gnt && waitrequest) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU's Avalon-style memory bus. It shares a single memory port between the instruction-fetch master (m0) and the load/store master (m1). Arbitration is round-robin, and a grant is held until the slave completes the transfer. A watchdog aborts transfers that the slave stalls indefinitely. It sits between the CPU's internal fetch/data units and the external bus (address, read, write, writedata, byteenable, readdata, waitrequest).

Parameters:
TIMEOUT, 256, slave stall cycles allowed before a transfer is aborted; 0 disables the watchdog.
CNT_W, 9, width of the stall counter; must hold TIMEOUT.

Ports:
clk  in  1  single clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
m0_address  in  32  fetch master byte address
m0_read  in  1  fetch master read request
m0_write  in  1  fetch master write request
m0_writedata  in  32  fetch master write data
m0_byteenable  in  4  fetch master byte lanes
m0_readdata  out  32  read data returned to m0
m0_waitrequest  out  1  stall to m0
m1_address / m1_read / m1_write / m1_writedata / m1_byteenable  in  32/1/1/32/4  data master, same meaning as m0
m1_readdata  out  32  read data returned to m1
m1_waitrequest  out  1  stall to m1
address  out  32  slave address
read  out  1  slave read strobe
write  out  1  slave write strobe
writedata  out  32  slave write data
byteenable  out  4  slave byte lanes
readdata  in  32  slave read data, valid in the completion cycle
waitrequest  in  1  slave stall
bus_error  out  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Request: mN_req = mN_read | mN_write. A master holds address, data and strobes stable while its waitrequest is high. If read and write are both high, the request is treated as a write and the read is ignored.
- States: IDLE, GNT0, GNT1. The state, the last-granted pointer `last` and the stall counter are registered.
- Reset (asynchronous, active-high): state=IDLE, last=1 (so m0 wins the first tie), counter=0. Slave read/write=0, address/writedata/byteenable=0, bus_error=0, m0/m1_waitrequest=1, m0/m1_readdata=0.
- IDLE: slave strobes are low. If only one master requests, grant it. If both request, grant the master != last. The transition takes effect at the next edge, so a request raised in cycle N drives the slave from cycle N+1.
- GNTk: slave outputs are driven combinationally from master k's signals.
- Completion: a cycle in GNTk with slave waitrequest=0. In that cycle mk_waitrequest=0 and mk_readdata=readdata (combinational). On the next edge: last=k, state=IDLE, counter=0.
- There is always one IDLE cycle between grants. Back-to-back requests from the same master therefore take at least 2 cycles each.
- The non-granted master, and the granted master while the slave stalls, see waitrequest=1. Readdata to any master is 0 whenever that master's waitrequest=1.
- Watchdog: in GNTk, the counter increments each cycle the slave holds waitrequest=1.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 while waitrequest is still 1, the transfer is aborted in that cycle.
  - Abort drives mk_waitrequest=0, mk_readdata=0, bus_error=1 and slave strobes=0. The next state is IDLE with last=k.
- Simultaneous slave completion and timeout in the same cycle is a normal completion; no error is raised.
- A master dropping its request mid-grant is illegal. The arbiter stays in GNTk until completion or timeout.
- Reset asserted mid-transfer aborts immediately and asynchronously, with no bus_error pulse.

Test Plan:
- Single m0 read of 0xBFC00000; slave waitrequest high 2 cycles, then readdata=0x3C020070 -> slave read high cycles N+1..N+3; m0_waitrequest low only in N+3 with m0_readdata=0x3C020070; m1_waitrequest stays 1.
- m0 and m1 raise requests in the same cycle after reset; zero-wait slave -> m0 granted first, IDLE cycle, then m1; the next simultaneous pair grants m0 again (alternation).
- m1 write 0x00701F00 to 0xBFC00100 with byteenable=4'b1100 -> slave sees exactly those address, data and byteenable values with write=1 and read=0 for the grant duration.
- m0 continuously requesting while m1 requests once -> m1 granted at the next IDLE after m0's current transfer completes; no starvation over 10 cycles.
- TIMEOUT=4; slave holds waitrequest=1 forever on an m1 read -> in the 4th grant cycle m1_waitrequest=0, m1_readdata=0, bus_error=1 for exactly one cycle; state returns to IDLE.
- reset asserted between edges mid-GNT0 -> read/write drop to 0 and both waitrequests go to 1 without waiting for a clock edge; the first grant after release goes to m0.
